// File: rtl/ahb_slave_mux_s1.sv
// rtl/ahb_slave_mux_s1.sv - slave 1 address/data mux with data-phase owner tracking,
// ERROR-response cancellation and sticky grant/error status.
module ahb_slave_mux_s1 #(
  parameter int MASTER_NUM    = 3,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                  hclk,
  input  logic                                  hreset_n,
  input  logic [MASTER_NUM-1:0]                 hgrant,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]            m_htrans,
  input  logic [MASTER_NUM-1:0]                 m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]            m_hsize,
  input  logic [MASTER_NUM-1:0][2:0]            m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_hwdata,
  input  logic                                  s_hreadyout,
  input  logic                                  s_hresp,
  input  logic [DATA_WIDTH-1:0]                 s_hrdata,
  output logic [ADDR_WIDTH-1:0]                 s_haddr,
  output logic [1:0]                            s_htrans,
  output logic                                  s_hwrite,
  output logic [2:0]                            s_hsize,
  output logic [DATA_WIDTH-1:0]                 s_hwdata,
  output logic                                  s_hready,
  output logic [2:0]                            hburst,
  output logic                                  hwait,
  output logic [MASTER_NUM-1:0]                 m_hreadyout,
  output logic [MASTER_NUM-1:0]                 m_hresp,
  output logic [DATA_WIDTH-1:0]                 m_hrdata,
  output logic                                  grant_err,
  output logic [ERR_CNT_WIDTH-1:0]              err_cnt
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic {ST_OK, ST_ERR1} err_state_t;

  err_state_t                state, state_nxt;
  logic [MASTER_NUM-1:0]     data_owner;
  logic                      grant_multi;
  logic                      grant_valid;
  logic [1:0]                a_htrans;

  // Address fields are also suppressed while reset is asserted so the slave sees IDLE at once.
  assign grant_multi = |(hgrant & (hgrant - MASTER_NUM'(1)));
  assign grant_valid = hreset_n && (hgrant != '0) && !grant_multi;

  always_comb begin
    s_haddr  = '0;
    a_htrans = HTRANS_IDLE;
    s_hwrite = 1'b0;
    s_hsize  = 3'd0;
    hburst   = 3'd0;
    if (grant_valid) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (hgrant[i]) begin
          s_haddr  = m_haddr[i];
          a_htrans = m_htrans[i];
          s_hwrite = m_hwrite[i];
          s_hsize  = m_hsize[i];
          hburst   = m_hburst[i];
        end
      end
    end
  end

  // Second ERROR cycle cancels whatever transfer is in the address phase.
  always_comb begin
    state_nxt = state;
    s_htrans  = a_htrans;
    case (state)
      ST_OK:   if (s_hresp && !s_hreadyout) state_nxt = ST_ERR1;
      ST_ERR1: begin
        state_nxt = ST_OK;
        s_htrans  = HTRANS_IDLE;
      end
      default: state_nxt = ST_OK;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) state <= ST_OK;
    else           state <= state_nxt;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      data_owner <= '0;
      err_cnt    <= '0;
      grant_err  <= 1'b0;
    end else begin
      if (s_hreadyout) data_owner <= (grant_valid && s_htrans[1]) ? hgrant : '0;
      if (state == ST_OK && state_nxt == ST_ERR1 && err_cnt != '1)
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      if (grant_multi) grant_err <= 1'b1;
    end
  end

  always_comb begin
    s_hwdata = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_hreadyout[i] = data_owner[i] ? s_hreadyout : 1'b1;
      m_hresp[i]     = data_owner[i] ? s_hresp : 1'b0;
      if (data_owner[i]) s_hwdata = m_hwdata[i];
    end
  end

  assign s_hready = s_hreadyout;
  assign hwait    = ~s_hreadyout;
  assign m_hrdata = s_hrdata;

endmodule

// File: tb/tb_ahb_slave_mux_s1.sv
// tb/tb_ahb_slave_mux_s1.sv - table-driven scoreboard bench for ahb_slave_mux_s1.
module tb_ahb_slave_mux_s1;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic [2:0]       hgrant;
  logic [2:0][31:0] m_haddr;
  logic [2:0][1:0]  m_htrans;
  logic [2:0]       m_hwrite;
  logic [2:0][2:0]  m_hsize;
  logic [2:0][2:0]  m_hburst;
  logic [2:0][31:0] m_hwdata;
  logic             s_hreadyout;
  logic             s_hresp;
  logic [31:0]      s_hrdata;
  logic [31:0]      s_haddr;
  logic [1:0]       s_htrans;
  logic             s_hwrite;
  logic [2:0]       s_hsize;
  logic [31:0]      s_hwdata;
  logic             s_hready;
  logic [2:0]       hburst;
  logic             hwait;
  logic [2:0]       m_hreadyout;
  logic [2:0]       m_hresp;
  logic [31:0]      m_hrdata;
  logic             grant_err;
  logic [7:0]       err_cnt;

  ahb_slave_mux_s1 dut (
    .hclk(hclk), .hreset_n(hreset_n), .hgrant(hgrant),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .hburst(hburst), .hwait(hwait), .m_hreadyout(m_hreadyout),
    .m_hresp(m_hresp), .m_hrdata(m_hrdata), .grant_err(grant_err),
    .err_cnt(err_cnt)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [2:0]  gnt;
    logic [5:0]  trans;
    logic        rdy;
    logic        resp;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [2:0]  e_burst;
    logic [2:0]  e_rdy;
    logic [2:0]  e_resp;
    logic [31:0] e_wdata;
    logic        e_wait;
    logic [7:0]  e_cnt;
    logic        e_gerr;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] rdata);
    hgrant      = v.gnt;
    m_htrans    = v.trans;
    s_hreadyout = v.rdy;
    s_hresp     = v.resp;
    s_hrdata    = rdata;
  endtask

  initial begin
    vec_t e;
    m_haddr  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0400};
    m_hwdata = {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h1111_1111};
    m_hburst = {3'd1, 3'd0, 3'd3};
    m_hsize  = {3'd2, 3'd2, 3'd2};
    m_hwrite = 3'b011;
    m_htrans = '0;
    hgrant = 3'b000; s_hreadyout = 1'b0; s_hresp = 1'b0; s_hrdata = '0;

    //        gnt     trans {m2,m1,m0}      rdy  rsp  trn   addr          brst  mrdy    mrsp    wdata          wait cnt  gerr
    vecs[0]  = '{3'b010, {2'd0,2'd2,2'd0}, 1'b1,1'b0,2'd2,32'h0000_1000,3'd0,3'b111,3'b000,32'h0,          1'b0,8'd0,1'b0};
    vecs[1]  = '{3'b000, {2'd0,2'd0,2'd0}, 1'b1,1'b0,2'd0,32'h0,        3'd0,3'b111,3'b000,32'hA5A5_A5A5,1'b0,8'd0,1'b0};
    vecs[2]  = '{3'b001, {2'd0,2'd0,2'd2}, 1'b1,1'b0,2'd2,32'h0000_0400,3'd3,3'b111,3'b000,32'h0,          1'b0,8'd0,1'b0};
    vecs[3]  = '{3'b100, {2'd2,2'd0,2'd0}, 1'b0,1'b0,2'd2,32'h0000_2000,3'd1,3'b110,3'b000,32'h1111_1111,1'b1,8'd0,1'b0};
    vecs[4]  = vecs[3];
    vecs[5]  = vecs[3];
    vecs[6]  = '{3'b100, {2'd2,2'd0,2'd0}, 1'b1,1'b0,2'd2,32'h0000_2000,3'd1,3'b111,3'b000,32'h1111_1111,1'b0,8'd0,1'b0};
    vecs[7]  = '{3'b000, {2'd0,2'd0,2'd0}, 1'b1,1'b0,2'd0,32'h0,        3'd0,3'b111,3'b000,32'h5A5A_5A5A,1'b0,8'd0,1'b0};
    vecs[8]  = '{3'b010, {2'd0,2'd2,2'd0}, 1'b1,1'b0,2'd2,32'h0000_1000,3'd0,3'b111,3'b000,32'h0,          1'b0,8'd0,1'b0};
    vecs[9]  = '{3'b010, {2'd0,2'd3,2'd0}, 1'b0,1'b1,2'd3,32'h0000_1000,3'd0,3'b101,3'b010,32'hA5A5_A5A5,1'b1,8'd0,1'b0};
    vecs[10] = '{3'b001, {2'd0,2'd3,2'd2}, 1'b1,1'b1,2'd0,32'h0000_0400,3'd3,3'b111,3'b010,32'hA5A5_A5A5,1'b0,8'd1,1'b0};
    vecs[11] = '{3'b000, {2'd0,2'd0,2'd0}, 1'b1,1'b0,2'd0,32'h0,        3'd0,3'b111,3'b000,32'h0,          1'b0,8'd1,1'b0};
    vecs[12] = '{3'b011, {2'd0,2'd2,2'd2}, 1'b1,1'b0,2'd0,32'h0,        3'd0,3'b111,3'b000,32'h0,          1'b0,8'd1,1'b0};
    vecs[13] = '{3'b001, {2'd0,2'd0,2'd2}, 1'b1,1'b0,2'd2,32'h0000_0400,3'd3,3'b111,3'b000,32'h0,          1'b0,8'd1,1'b1};
    vecs[14] = '{3'b000, {2'd0,2'd0,2'd0}, 1'b1,1'b0,2'd0,32'h0,        3'd0,3'b111,3'b000,32'h1111_1111,1'b0,8'd1,1'b1};

    // reset state, with a grant presented to show the address path is held off
    hreset_n = 1'b0;
    hgrant = 3'b001; m_htrans = {2'd0, 2'd0, 2'd2};
    #12;
    chk("rst s_htrans", 32'(s_htrans), 32'd0);
    chk("rst s_haddr", s_haddr, 32'h0);
    chk("rst s_hwdata", s_hwdata, 32'h0);
    chk("rst m_hreadyout", 32'(m_hreadyout), 32'h7);
    chk("rst m_hresp", 32'(m_hresp), 32'h0);
    chk("rst hburst", 32'(hburst), 32'h0);
    chk("rst hwait", 32'(hwait), 32'h1);
    chk("rst grant_err", 32'(grant_err), 32'h0);
    chk("rst err_cnt", 32'(err_cnt), 32'h0);
    hgrant = 3'b000; m_htrans = '0; s_hreadyout = 1'b1;
    @(posedge hclk); #1 hreset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      @(posedge hclk); #1;
      drive(vecs[k], 32'h0101_0101 * k);
      sb.push_back(vecs[k]);
      @(negedge hclk);
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty[%0d]", k), 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("s_htrans[%0d]", k), 32'(s_htrans), 32'(e.e_trans));
        chk($sformatf("s_haddr[%0d]", k), s_haddr, e.e_addr);
        chk($sformatf("hburst[%0d]", k), 32'(hburst), 32'(e.e_burst));
        chk($sformatf("m_hreadyout[%0d]", k), 32'(m_hreadyout), 32'(e.e_rdy));
        chk($sformatf("m_hresp[%0d]", k), 32'(m_hresp), 32'(e.e_resp));
        chk($sformatf("s_hwdata[%0d]", k), s_hwdata, e.e_wdata);
        chk($sformatf("hwait[%0d]", k), 32'(hwait), 32'(e.e_wait));
        chk($sformatf("s_hready[%0d]", k), 32'(s_hready), 32'(e.rdy));
        chk($sformatf("err_cnt[%0d]", k), 32'(err_cnt), 32'(e.e_cnt));
        chk($sformatf("grant_err[%0d]", k), 32'(grant_err), 32'(e.e_gerr));
        chk($sformatf("m_hrdata[%0d]", k), m_hrdata, 32'h0101_0101 * k);
      end
    end

    // err_cnt saturation: 260 further two-cycle ERROR responses
    hgrant = 3'b000; m_htrans = '0;
    for (int n = 0; n < 260; n++) begin
      @(posedge hclk); #1 s_hresp = 1'b1; s_hreadyout = 1'b0;
      @(posedge hclk); #1 s_hresp = 1'b1; s_hreadyout = 1'b1;
      if (n == 9) begin
        @(negedge hclk);
        chk("err_cnt after 11 errors", 32'(err_cnt), 32'd11);
      end
    end
    @(posedge hclk); #1 s_hresp = 1'b0; s_hreadyout = 1'b1;
    @(negedge hclk);
    chk("err_cnt saturated", 32'(err_cnt), 32'hFF);

    // async reset during an INCR4 burst, data phase of beat 2 stalled
    @(posedge hclk); #1 hgrant = 3'b001; m_htrans = {2'd0, 2'd0, 2'd2};
    @(posedge hclk); #1 m_htrans = {2'd0, 2'd0, 2'd3};
    @(posedge hclk); #1 s_hreadyout = 1'b0;
    @(negedge hclk);
    chk("burst m_hreadyout", 32'(m_hreadyout), 32'h6);
    chk("burst s_htrans", 32'(s_htrans), 32'd3);
    chk("burst s_hwdata", s_hwdata, 32'h1111_1111);
    #2 hreset_n = 1'b0;
    #1;
    chk("mid-rst m_hreadyout", 32'(m_hreadyout), 32'h7);
    chk("mid-rst s_htrans", 32'(s_htrans), 32'd0);
    chk("mid-rst s_haddr", s_haddr, 32'h0);
    chk("mid-rst hburst", 32'(hburst), 32'h0);
    chk("mid-rst s_hwdata", s_hwdata, 32'h0);
    chk("mid-rst err_cnt", 32'(err_cnt), 32'h0);
    chk("mid-rst grant_err", 32'(grant_err), 32'h0);
    chk("mid-rst hwait", 32'(hwait), 32'h1);
    @(posedge hclk); #1 hreset_n = 1'b1;
    @(negedge hclk);
    chk("post-rst s_htrans", 32'(s_htrans), 32'd3);
    chk("post-rst m_hreadyout", 32'(m_hreadyout), 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
